vector_reduce_accum_unit: RTL and testbench
===========================================

VECTOR_REDUCE_ACCUM_UNIT -- requirements
Module: vector_reduce_accum_unit

Interface
REQ-001 Parameter N, default 8, meaning vector lane count (power of two, >=2).
REQ-002 Parameter M, default 4, meaning group count for group-sum mode (power of two, 1<=M<=N, N divisible by M).
REQ-003 Parameter DATA_WIDTH, default 32, meaning lane width in bits.
REQ-004 Ports SHALL be: one clock, `clk`; reset is asynchronous and active-low, `reset_n`.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 valid_in  input  1  vector_in valid this cycle.
REQ-008 eof_in  input  1  last vector of frame, qualified by valid_in.
REQ-009 chainId_in  input  1  accumulator bank select (0/1), qualified by valid_in.
REQ-010 vector_in  input  N x DATA_WIDTH  input lanes.
REQ-011 cfg_valid  input  1  load cfg_mode this cycle.
REQ-012 cfg_mode  input  2  0=pass, 1=sum-all, 2=group-sum, 3=frame-accumulate.
REQ-013 valid_out  output  1  vector_out valid.
REQ-014 eof_out  output  1  frame end marker aligned with valid_out.
REQ-015 vector_out  output  N x DATA_WIDTH  result lanes.

Function
REQ-016 Pipeline SHALL be two register stages: stage 1 registers the M group partial sums plus input copy/control; stage 2 registers outputs; latency from valid_in to valid_out SHALL be exactly 2 cycles in modes 0-2, full throughput, no backpressure.
REQ-017 All additions SHALL be two's-complement, modulo 2^DATA_WIDTH (wrap, no saturation, no width growth).
REQ-018 Mode 0: vector_out = vector_in unchanged.
REQ-019 Mode 1: vector_out[0] = sum of all N lanes; lanes 1..N-1 = 0.
REQ-020 Mode 2: vector_out[g] = sum of lanes g*(N/M) .. (g+1)*(N/M)-1 for g<M; lanes M..N-1 = 0; M=1 equals mode 1.
REQ-021 Modes 0-2: eof_out = eof_in delayed 2 cycles; chainId ignored.
REQ-022 Mode 3: two banks of N per-lane accumulators; each valid_in adds vector_in lane-wise into bank[chainId_in]; valid_out SHALL be 0 for non-eof inputs.
REQ-023 Mode 3 on valid_in&eof_in: bank total including that vector SHALL appear on vector_out with valid_out=1, eof_out=1 exactly 2 cycles later; that bank SHALL be cleared in the same cycle, so a valid_in to the same bank the next cycle starts from 0.
REQ-024 Mode 3: banks SHALL be independent; eof on bank 0 SHALL NOT alter bank 1.
REQ-025 Mode register SHALL update on the clock edge where cfg_valid=1; an input with valid_in on that same edge SHALL use the old mode; inputs from the next edge on use the new mode; in-flight stage-1/2 data SHALL complete under the mode they were accepted with.
REQ-026 Any cfg_valid (even same mode) SHALL clear both accumulator banks.
REQ-027 valid_in=0 cycles SHALL not modify accumulators; valid_out=0 then carries vector_out unchanged (hold last value).
REQ-028 eof_in with valid_in=0 SHALL be ignored.

Reset
REQ-029 reset_n=0 SHALL asynchronously clear valid_out, eof_out, all vector_out lanes, both pipeline stages and both accumulator banks to 0, and set mode to 1 (sum-all).
REQ-030 Reset asserted mid-frame SHALL discard partial accumulations and in-flight vectors; no valid_out from pre-reset inputs after release.
REQ-031 First valid_in accepted on first rising edge with reset_n=1 SHALL be processed normally.

Verification
REQ-032 After reset, mode 1, N=8, vector_in={1..8}, valid_in=1 at cycle 0 -> cycle 2: valid_out=1, vector_out[0]=36, lanes 1..7=0.
REQ-033 Mode 2, M=4, vector_in={1..8} -> vector_out={3,7,11,15,0,0,0,0} after 2 cycles; mode 0 same input -> {1..8}.
REQ-034 Mode 3: bank0 gets {1,...,1} x3 with eof on third, bank1 interleaved {2,...,2} x2 with eof on second -> bank1 output all lanes 4 and bank0 all lanes 3, each 2 cycles after its eof, eof_out=1, no other valid_out.
REQ-035 DATA_WIDTH=8, mode 1, all lanes 0xFF -> vector_out[0]=0xF8 (wrap).
REQ-036 Mode 3, two vectors into bank0 without eof, then cfg_valid (mode 3) and eof vector {5,...} -> output all lanes 5; separately reset_n pulse mid-frame -> subsequent eof frame contains only post-reset sum.
REQ-037 cfg_valid to mode 0 coincident with valid_in in mode 1 -> that vector emitted as sum-all, next vector passed through.

Source files
------------

// File: rtl/vector_reduce_accum_unit_if.sv
// Streaming vector bus for vector_reduce_accum_unit: input vector, config load and result vector.
interface vector_reduce_accum_unit_if #(
   parameter int unsigned N          = 8,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                             valid_in;
   logic                             eof_in;
   logic                             chainId_in;
   logic [N-1:0][DATA_WIDTH-1:0]     vector_in;
   logic                             cfg_valid;
   logic [1:0]                       cfg_mode;
   logic                             valid_out;
   logic                             eof_out;
   logic [N-1:0][DATA_WIDTH-1:0]     vector_out;

   modport master (
      output valid_in, eof_in, chainId_in, vector_in, cfg_valid, cfg_mode,
      input  valid_out, eof_out, vector_out
   );

   modport slave (
      input  valid_in, eof_in, chainId_in, vector_in, cfg_valid, cfg_mode,
      output valid_out, eof_out, vector_out
   );
endinterface

// File: rtl/vector_reduce_accum_unit.sv
// Two-stage vector reducer: pass-through, sum-all, group-sum, or dual-bank per-lane
// frame accumulation; all arithmetic wraps modulo 2^DATA_WIDTH.
module vector_reduce_accum_unit #(
   parameter int unsigned N          = 8,
   parameter int unsigned M          = 4,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          reset_n,
   vector_reduce_accum_unit_if.slave     bus
);
   localparam int unsigned G  = N / M;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned MW = (M > 1) ? $clog2(M) : 1;

   typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;
   typedef logic [M-1:0][DATA_WIDTH-1:0] grp_t;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_SUM   = 2'd1,
      MODE_GROUP = 2'd2,
      MODE_ACCUM = 2'd3
   } mode_e;

   mode_e  mode_q, mode_d;
   vec_t   bank_q [2];
   vec_t   bank_d [2];

   logic   s1_valid_q, s1_valid_d;
   logic   s1_eof_q,   s1_eof_d;
   mode_e  s1_mode_q,  s1_mode_d;
   vec_t   s1_data_q,  s1_data_d;
   grp_t   s1_grp_q,   s1_grp_d;

   logic   out_valid_q, out_valid_d;
   logic   out_eof_q,   out_eof_d;
   vec_t   out_vec_q,   out_vec_d;

   grp_t   grp_sum_c;
   vec_t   acc_sum_c;

   // Group partial sums of the incoming vector; sum-all later folds these together.
   always_comb begin : group_sums
      grp_sum_c = '0;
      for (int unsigned g = 0; g < M; g++) begin
         for (int unsigned k = 0; k < G; k++) begin
            grp_sum_c[MW'(g)] = grp_sum_c[MW'(g)] + bus.vector_in[IW'(g * G + k)];
         end
      end
   end

   // Lane-wise running total of the selected bank including the current vector.
   always_comb begin : bank_sums
      acc_sum_c = '0;
      for (int unsigned l = 0; l < N; l++) begin
         acc_sum_c[IW'(l)] = bank_q[bus.chainId_in][IW'(l)] + bus.vector_in[IW'(l)];
      end
   end

   // Stage 1 capture, bank update and mode load; config load always wipes both banks.
   always_comb begin : stage1_next
      mode_d     = mode_q;
      bank_d[0]  = bank_q[0];
      bank_d[1]  = bank_q[1];
      s1_valid_d = 1'b0;
      s1_eof_d   = 1'b0;
      s1_mode_d  = s1_mode_q;
      s1_data_d  = s1_data_q;
      s1_grp_d   = s1_grp_q;

      if (bus.valid_in) begin
         s1_mode_d = mode_q;
         s1_eof_d  = bus.eof_in;
         s1_grp_d  = grp_sum_c;
         if (mode_q == MODE_ACCUM) begin
            s1_valid_d = bus.eof_in;
            s1_data_d  = acc_sum_c;
            bank_d[bus.chainId_in] = bus.eof_in ? '0 : acc_sum_c;
         end else begin
            s1_valid_d = 1'b1;
            s1_data_d  = bus.vector_in;
         end
      end

      if (bus.cfg_valid) begin
         mode_d    = mode_e'(bus.cfg_mode);
         bank_d[0] = '0;
         bank_d[1] = '0;
      end
   end

   // Stage 2 result formation under the mode the vector was accepted with; hold when idle.
   always_comb begin : stage2_next
      out_valid_d = s1_valid_q;
      out_eof_d   = s1_valid_q & s1_eof_q;
      out_vec_d   = out_vec_q;

      if (s1_valid_q) begin
         unique case (s1_mode_q)
            MODE_SUM: begin
               out_vec_d = '0;
               for (int unsigned g = 0; g < M; g++) begin
                  out_vec_d[0] = out_vec_d[0] + s1_grp_q[MW'(g)];
               end
            end
            MODE_GROUP: begin
               out_vec_d = '0;
               for (int unsigned g = 0; g < M; g++) begin
                  out_vec_d[IW'(g)] = s1_grp_q[MW'(g)];
               end
            end
            default: out_vec_d = s1_data_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin : state_regs
      if (!reset_n) begin
         mode_q      <= MODE_SUM;
         bank_q[0]   <= '0;
         bank_q[1]   <= '0;
         s1_valid_q  <= 1'b0;
         s1_eof_q    <= 1'b0;
         s1_mode_q   <= MODE_SUM;
         s1_data_q   <= '0;
         s1_grp_q    <= '0;
         out_valid_q <= 1'b0;
         out_eof_q   <= 1'b0;
         out_vec_q   <= '0;
      end else begin
         mode_q      <= mode_d;
         bank_q[0]   <= bank_d[0];
         bank_q[1]   <= bank_d[1];
         s1_valid_q  <= s1_valid_d;
         s1_eof_q    <= s1_eof_d;
         s1_mode_q   <= s1_mode_d;
         s1_data_q   <= s1_data_d;
         s1_grp_q    <= s1_grp_d;
         out_valid_q <= out_valid_d;
         out_eof_q   <= out_eof_d;
         out_vec_q   <= out_vec_d;
      end
   end

   assign bus.valid_out  = out_valid_q;
   assign bus.eof_out    = out_eof_q;
   assign bus.vector_out = out_vec_q;

endmodule

// File: tb/tb_vector_reduce_accum_unit.sv
// Directed plus randomized bench for vector_reduce_accum_unit against a cycle-level reference model.
module tb_vector_reduce_accum_unit;
   localparam int unsigned N  = 8;
   localparam int unsigned M  = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned NW = 8;
   localparam int unsigned IW = 3;

   typedef logic [N-1:0][DW-1:0] vec_t;
   typedef logic [N-1:0][NW-1:0] nvec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   vector_reduce_accum_unit_if #(.N(N), .DATA_WIDTH(DW)) bus ();
   vector_reduce_accum_unit_if #(.N(N), .DATA_WIDTH(NW)) nbus ();

   vector_reduce_accum_unit #(.N(N), .M(M), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus.slave));

   vector_reduce_accum_unit #(.N(N), .M(M), .DATA_WIDTH(NW)) dut_narrow (
      .clk(clk), .reset_n(reset_n), .bus(nbus.slave));

   int checks = 0;
   int errors = 0;

   // Reference model state
   int   mdl_mode;
   vec_t mdl_bank [2];
   logic pend_valid, pend_eof, exp_valid, exp_eof;
   vec_t pend_vec, exp_vec;

   function automatic vec_t ramp();
      vec_t v;
      for (int i = 0; i < int'(N); i++) v[IW'(i)] = DW'(i + 1);
      return v;
   endfunction

   function automatic vec_t fill(input logic [DW-1:0] x);
      vec_t v;
      for (int i = 0; i < int'(N); i++) v[IW'(i)] = x;
      return v;
   endfunction

   function automatic vec_t ref_result(input int mode, input vec_t v);
      vec_t r = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (mode == 0) r[IW'(i)] = v[IW'(i)];
         else if (mode == 1) r[0] = r[0] + v[IW'(i)];
         else r[IW'(i / int'(N / M))] = r[IW'(i / int'(N / M))] + v[IW'(i)];
      end
      return r;
   endfunction

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check_vec(input string tag, input vec_t obs, input vec_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_nvec(input string tag, input nvec_t obs, input nvec_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mdl_mode   = 1;
      mdl_bank[0] = '0;
      mdl_bank[1] = '0;
      pend_valid = 1'b0;
      pend_eof   = 1'b0;
      pend_vec   = '0;
      exp_valid  = 1'b0;
      exp_eof    = 1'b0;
      exp_vec    = '0;
   endtask

   task automatic drive_idle();
      bus.valid_in   = 1'b0;
      bus.eof_in     = 1'b0;
      bus.chainId_in = 1'b0;
      bus.vector_in  = '0;
      bus.cfg_valid  = 1'b0;
      bus.cfg_mode   = 2'd0;
      nbus.valid_in   = 1'b0;
      nbus.eof_in     = 1'b0;
      nbus.chainId_in = 1'b0;
      nbus.vector_in  = '0;
      nbus.cfg_valid  = 1'b0;
      nbus.cfg_mode   = 2'd0;
   endtask

   // One clock: drive, advance model at the edge, then compare outputs just after it.
   task automatic step(input logic v, input logic e, input logic c, input vec_t vec,
                       input logic cv, input logic [1:0] cm);
      logic nv, ne;
      vec_t nvec;
      bus.valid_in   = v;
      bus.eof_in     = e;
      bus.chainId_in = c;
      bus.vector_in  = vec;
      bus.cfg_valid  = cv;
      bus.cfg_mode   = cm;
      @(posedge clk);
      nv = 1'b0; ne = 1'b0; nvec = '0;
      if (v) begin
         if (mdl_mode == 3) begin
            for (int i = 0; i < int'(N); i++)
               mdl_bank[c][IW'(i)] = mdl_bank[c][IW'(i)] + vec[IW'(i)];
            if (e) begin
               nv = 1'b1; ne = 1'b1; nvec = mdl_bank[c];
               mdl_bank[c] = '0;
            end
         end else begin
            nv = 1'b1; ne = e; nvec = ref_result(mdl_mode, vec);
         end
      end
      if (cv) begin
         mdl_mode = int'(cm);
         mdl_bank[0] = '0;
         mdl_bank[1] = '0;
      end
      exp_valid = pend_valid;
      exp_eof   = pend_eof;
      if (pend_valid) exp_vec = pend_vec;
      pend_valid = nv; pend_eof = ne; pend_vec = nvec;
      #1;
      check_bit("valid_out", bus.valid_out, exp_valid);
      check_bit("eof_out", bus.eof_out, exp_eof);
      check_vec("vector_out", bus.vector_out, exp_vec);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, '0, 1'b0, 2'd0);
   endtask

   task automatic cfg(input logic [1:0] m);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, m);
   endtask

   // Asynchronous reset pulse landing mid-cycle; outputs must clear without a clock edge.
   task automatic pulse_reset(input int cycles);
      #2;
      drive_idle();
      reset_n = 1'b0;
      #1;
      check_bit("rst_valid_out", bus.valid_out, 1'b0);
      check_bit("rst_eof_out", bus.eof_out, 1'b0);
      check_vec("rst_vector_out", bus.vector_out, '0);
      model_reset();
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      vec_t  x;
      nvec_t nv, nexp;
      logic [NW-1:0] nsum;

      drive_idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_bit("init_valid_out", bus.valid_out, 1'b0);
      check_bit("init_eof_out", bus.eof_out, 1'b0);
      check_vec("init_vector_out", bus.vector_out, '0);
      @(negedge clk);
      reset_n = 1'b1;

      // Default mode is sum-all; first vector after release is processed.
      step(1'b1, 1'b0, 1'b0, ramp(), 1'b0, 2'd0);
      idle(1);
      x = '0; x[0] = 32'd36;
      check_vec("sumall_1to8", bus.vector_out, x);
      check_bit("sumall_valid", bus.valid_out, 1'b1);

      cfg(2'd2);
      step(1'b1, 1'b1, 1'b0, ramp(), 1'b0, 2'd0);
      idle(1);
      x = '0; x[0] = 32'd3; x[1] = 32'd7; x[2] = 32'd11; x[3] = 32'd15;
      check_vec("groupsum_1to8", bus.vector_out, x);
      check_bit("groupsum_eof", bus.eof_out, 1'b1);

      cfg(2'd0);
      step(1'b1, 1'b0, 1'b0, ramp(), 1'b0, 2'd0);
      idle(1);
      check_vec("pass_1to8", bus.vector_out, ramp());
      idle(2);
      check_vec("hold_after_pass", bus.vector_out, ramp());

      // Mode change coinciding with a vector: that vector keeps the old mode.
      cfg(2'd1);
      step(1'b1, 1'b0, 1'b0, ramp(), 1'b1, 2'd0);
      step(1'b1, 1'b0, 1'b0, ramp(), 1'b0, 2'd0);
      x = '0; x[0] = 32'd36;
      check_vec("cfg_edge_old_mode", bus.vector_out, x);
      idle(1);
      check_vec("cfg_edge_new_mode", bus.vector_out, ramp());

      // Interleaved two-bank frames.
      cfg(2'd3);
      step(1'b1, 1'b0, 1'b0, fill(32'd1), 1'b0, 2'd0);
      step(1'b1, 1'b0, 1'b1, fill(32'd2), 1'b0, 2'd0);
      step(1'b1, 1'b0, 1'b0, fill(32'd1), 1'b0, 2'd0);
      step(1'b1, 1'b1, 1'b1, fill(32'd2), 1'b0, 2'd0);
      step(1'b1, 1'b1, 1'b0, fill(32'd1), 1'b0, 2'd0);
      check_vec("bank1_total", bus.vector_out, fill(32'd4));
      check_bit("bank1_eof", bus.eof_out, 1'b1);
      idle(1);
      check_vec("bank0_total", bus.vector_out, fill(32'd3));
      check_bit("bank0_eof", bus.eof_out, 1'b1);
      idle(1);
      check_bit("no_extra_valid", bus.valid_out, 1'b0);

      // Config load discards a partial frame.
      step(1'b1, 1'b0, 1'b0, ramp(), 1'b0, 2'd0);
      step(1'b1, 1'b0, 1'b0, ramp(), 1'b0, 2'd0);
      cfg(2'd3);
      step(1'b1, 1'b1, 1'b0, fill(32'd5), 1'b0, 2'd0);
      idle(1);
      check_vec("cfg_clears_bank", bus.vector_out, fill(32'd5));

      // Reset mid-frame discards the partial sum.
      step(1'b1, 1'b0, 1'b0, fill(32'd9), 1'b0, 2'd0);
      step(1'b1, 1'b1, 1'b1, fill(32'd6), 1'b0, 2'd0);
      pulse_reset(2);
      idle(2);
      cfg(2'd3);
      step(1'b1, 1'b1, 1'b0, fill(32'd7), 1'b0, 2'd0);
      idle(1);
      check_vec("post_reset_frame", bus.vector_out, fill(32'd7));

      // Narrow lanes wrap: eight 0xFF lanes sum to 0xF8.
      nbus.valid_in  = 1'b1;
      nbus.vector_in = {N{8'hFF}};
      idle(1);
      nbus.valid_in = 1'b0;
      idle(1);
      nexp = '0; nexp[0] = 8'hF8;
      check_bit("narrow_valid", nbus.valid_out, 1'b1);
      check_nvec("narrow_wrap", nbus.vector_out, nexp);
      nsum = '0;
      for (int i = 0; i < int'(N); i++) begin
         nv[IW'(i)] = NW'($urandom_range(255));
         nsum = nsum + nv[IW'(i)];
      end
      nbus.valid_in  = 1'b1;
      nbus.vector_in = nv;
      idle(1);
      nbus.valid_in = 1'b0;
      idle(1);
      nexp = '0; nexp[0] = nsum;
      check_nvec("narrow_random", nbus.vector_out, nexp);

      // Randomized traffic, with one asynchronous reset in the middle.
      for (int t = 0; t < 400; t++) begin
         vec_t rv;
         for (int i = 0; i < int'(N); i++) rv[IW'(i)] = $urandom;
         if (t == 200) pulse_reset(1);
         step(1'($urandom_range(3) != 0), 1'($urandom_range(3) == 0), 1'($urandom_range(1)),
              rv, 1'($urandom_range(15) == 0), 2'($urandom_range(3)));
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
